// File: rtl/arb4_rr_gea1.sv
`default_nettype none
// ============================================================================
// Module   : arb4_rr_gea1
// Brief    : Four-requester round-robin arbiter with a registered one-hot grant.
//            Optional hold-timeout watchdog enabled by ARB4_RR_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module arb4_rr_gea1 #(
    parameter int HOLD_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       gnt_vld,
    output logic [1:0] gnt_id,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic       r_gnt_vld;
    logic [1:0] r_gnt_id;

    logic       w_found;
    logic [1:0] w_winner;
    logic [1:0] w_idx;

    // First set request bit scanning upward from the rotating pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

`ifdef ARB4_RR_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;
    logic             w_expire;

    assign w_expire = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
    assign timeout  = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{HOLD_MAX[0], CNT_W[0]};
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_gnt     <= 4'b0000;
            r_gnt_vld <= 1'b0;
            r_gnt_id  <= 2'd0;
`ifdef ARB4_RR_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef ARB4_RR_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_gnt     <= 4'b0000;
                    r_gnt_vld <= 1'b0;
                    if (w_found) begin
                        r_gnt     <= 4'b0001 << w_winner;
                        r_gnt_vld <= 1'b1;
                        r_gnt_id  <= w_winner;
                        r_ptr     <= w_winner + 2'd1;
                        r_state   <= ST_BUSY;
`ifdef ARB4_RR_TIMEOUT_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    // req is ignored here; only the owner's release ends the grant.
                    if (done) begin
                        r_gnt     <= 4'b0000;
                        r_gnt_vld <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
`ifdef ARB4_RR_TIMEOUT_EN
                    else if (w_expire) begin
                        r_gnt     <= 4'b0000;
                        r_gnt_vld <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = r_gnt_vld;
    assign gnt_id  = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_arb4_rr_gea1.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb4_rr_gea1
// Brief    : Directed self-checking bench for arb4_rr_gea1.
// Revision : 1.0
// ============================================================================
module tb_arb4_rr_gea1;

`ifdef ARB4_RR_TIMEOUT_EN
    localparam int c_hold_max = 4;
`else
    localparam int c_hold_max = 255;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    arb4_rr_gea1 #(
        .HOLD_MAX (c_hold_max),
        .CNT_W    (8)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] eg, input logic [1:0] eid);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(eg != 4'b0000));
        chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        step();
        step();
        chk_gnt("reset", 4'b0000, 2'd0);
        chk("reset.timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Rotation with all requesting: 0,1,2,3,0 with an idle cycle between.
        step();
        chk_gnt("rot0", 4'b0001, 2'd0);
        done = 1'b1;
        step();
        chk_gnt("rot0_rel", 4'b0000, 2'd0);
        done = 1'b0;
        step();
        chk_gnt("rot1", 4'b0010, 2'd1);
        done = 1'b1;
        step();
        chk_gnt("rot1_rel", 4'b0000, 2'd1);
        done = 1'b0;
        step();
        chk_gnt("rot2", 4'b0100, 2'd2);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk_gnt("rot3", 4'b1000, 2'd3);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk_gnt("rot4", 4'b0001, 2'd0);
        chk("rot.timeout", 32'(timeout), 32'd0);

        // Skip/wrap: grant 2 moves ptr to 3, then 0011 wins 0 then 1.
        done = 1'b1;
        req  = 4'b0100;
        step();
        done = 1'b0;
        step();
        chk_gnt("wrap_g2", 4'b0100, 2'd2);
        done = 1'b1;
        req  = 4'b0011;
        step();
        done = 1'b0;
        step();
        chk_gnt("wrap_g0", 4'b0001, 2'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk_gnt("wrap_g1", 4'b0010, 2'd1);

`ifdef ARB4_RR_TIMEOUT_EN
        // Timeout: grant to 3, never released -> 4 cycles high then pulse.
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        req  = 4'b1000;
        step();
        chk_gnt("to_g", 4'b1000, 2'd3);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_gnt("to_hold", 4'b1000, 2'd3);
            chk("to_hold.timeout", 32'(timeout), 32'd0);
        end
        step();
        chk_gnt("to_fire", 4'b0000, 2'd3);
        chk("to_fire.timeout", 32'(timeout), 32'd1);
        step();
        chk("to_pulse_end", 32'(timeout), 32'd0);
        // done on the final allowed cycle wins over the watchdog.
        req = 4'b1000;
        step();
        chk_gnt("to2_g", 4'b1000, 2'd3);
        req = 4'b0000;
        step();
        step();
        step();
        chk_gnt("to2_c4", 4'b1000, 2'd3);
        done = 1'b1;
        step();
        chk_gnt("to2_rel", 4'b0000, 2'd3);
        chk("to2.timeout", 32'(timeout), 32'd0);
        done = 1'b0;
        step();
        chk("to2.timeout_after", 32'(timeout), 32'd0);
`else
        // Hold: owner drops req, grant persists until done.
        req = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold.gnt", 32'(gnt), 32'h2);
            chk("hold.timeout", 32'(timeout), 32'd0);
        end
        done = 1'b1;
        step();
        chk_gnt("hold_rel", 4'b0000, 2'd1);
        step();
        chk_gnt("idle_done", 4'b0000, 2'd1);
        done = 1'b0;
        step();
        chk_gnt("idle_done2", 4'b0000, 2'd1);
`endif

        // Async reset mid-grant.
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0100;
        step();
        chk_gnt("ar_g", 4'b0100, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_gnt("ar_clr", 4'b0000, 2'd0);
        chk("ar_clr.timeout", 32'(timeout), 32'd0);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        chk_gnt("ar_ptr0", 4'b0001, 2'd0);
        done = 1'b1;
        req  = 4'b0100;
        step();
        done = 1'b0;
        step();
        chk_gnt("ar_g2", 4'b0100, 2'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb4_rr_gea1.md
# arb4_rr_gea1

Four-requester round-robin arbiter sharing a single generic-cell resource (e.g. a shared gated datapath built from gea1 cells) between independent masters. Samples requests, issues a registered one-hot grant, holds it until the owner signals release, then rotates priority. Sits between requesting controllers and the shared resource's select/enable logic. Optional hold-timeout watchdog forcibly reclaims a stuck grant.

## Interface
Parameters:
- HOLD_MAX, 255, grant-hold limit in cycles for the timeout watchdog; legal range 1..2^CNT_W-1
- CNT_W, 8, width of the hold counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  4  request vector, bit i = requester i
- done  input  1  release strobe from current grant owner; sampled only in BUSY
- gnt  output  4  registered one-hot grant, all-zero when idle
- gnt_vld  output  1  registered; high when any gnt bit high
- gnt_id  output  2  registered binary index of current/last grant
- timeout  output  1  registered one-cycle pulse on forced release

## Operation
- States: IDLE, BUSY. Reset enters IDLE.
- IDLE: if req != 0, select winner = first set req bit scanning ptr, ptr+1, ... mod 4; next edge: gnt = onehot(winner), gnt_vld = 1, gnt_id = winner, ptr = winner+1 mod 4, state BUSY. If req == 0, stay IDLE, outputs unchanged except gnt/gnt_vld = 0.
- BUSY: req ignored (owner may drop req; grant persists). done = 1 -> next edge gnt = 0, gnt_vld = 0, state IDLE; gnt_id retains last winner.
- done in IDLE ignored.
- Minimum one IDLE cycle between consecutive grants; arbitration is evaluated only in IDLE.
- Fairness: any continuously asserted requester is granted within 3 intervening grants.
- Pointer ptr: 2 bits, reset 0, wraps 3 -> 0; advanced only on grant issue.

## Timing
- Reset values: gnt = 4'b0000, gnt_vld = 0, gnt_id = 2'd0, timeout = 0, ptr = 0, hold counter = 0, state IDLE. Reset asserted mid-grant clears everything immediately (asynchronous); no done/timeout emitted.
- req -> gnt latency: 1 cycle (req sampled high in IDLE at edge N, gnt high after edge N).
- done -> gnt low: 1 cycle.
- Simultaneous req from all four at reset: grant order 0,1,2,3,0,...
- gnt and gnt_vld always consistent; gnt never has more than one bit set.

## Configuration
- Macro ARB4_RR_TIMEOUT_EN.
- Defined: hold counter (CNT_W bits) cleared on grant issue, increments each BUSY cycle with done = 0. If in BUSY with done = 0 and counter == HOLD_MAX-1, next edge: gnt = 0, gnt_vld = 0, timeout = 1 (exactly one cycle), state IDLE. gnt therefore stays high at most HOLD_MAX cycles. done and timeout condition in same cycle: done wins, timeout stays 0. Pointer already advanced, so timed-out requester goes to back of rotation.
- Undefined: no counter logic, timeout tied 0, grant held indefinitely until done; HOLD_MAX and CNT_W unused.

## Test plan
- Reset: drive rst_n = 0 with req = 4'b1111 -> gnt = 0, gnt_vld = 0, gnt_id = 0, timeout = 0; release reset -> gnt = 4'b0001 one cycle after first sampling edge.
- Rotation: req = 4'b1111 held, done pulsed 1 cycle after each grant -> gnt sequence 0001, 1000-free cycles between, 0010, 0100, 1000, 0001; gnt_id 0,1,2,3,0.
- Skip/wrap: ptr = 3 (after grant to 2), req = 4'b0011 -> gnt = 4'b0001; next arbitration with req = 4'b0011 -> gnt = 4'b0010.
- Hold: grant to 1, drop req[1], done = 0 for 20 cycles (HOLD_MAX = 255) -> gnt stays 4'b0010; done = 1 -> gnt = 0 next cycle; done in IDLE has no effect.
- Timeout (ARB4_RR_TIMEOUT_EN, HOLD_MAX = 4): grant, never done -> gnt high exactly 4 cycles, then gnt = 0 with timeout = 1 for one cycle; repeat with done on 4th cycle -> timeout stays 0.
- Async reset mid-grant: rst_n low between edges while gnt = 4'b0100 -> gnt = 0 immediately, ptr back to 0; after release req = 4'b0100 -> gnt = 4'b0100.
